// File: rtl/pcs_sync.sv
// rtl/pcs_sync.sv - 1000BASE-X PCS receive synchronization (comma alignment, even/odd tracking, sync qualification)
module pcs_sync #(
  parameter int ACQ_COMMAS = 3,
  parameter int GOOD_CGS   = 3,
  parameter int BAD_LEVELS = 3
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic [9:0] rx_code_group_in,
  input  logic       signal_detect,
  output logic [9:0] rx_code_group_out,
  output logic       sync_status,
  output logic       rx_even
);

  localparam logic [3:0] ACQ_L  = 4'(ACQ_COMMAS);
  localparam logic [3:0] LAST_L = 4'(BAD_LEVELS + 1);
  localparam logic [1:0] GOOD_L = 2'(GOOD_CGS);

  // CD/AS use lvl as the comma-pair index k; SAN/SANA use it as the bad level n.
  typedef enum logic [2:0] {
    ST_LOS, ST_CD, ST_AS, ST_SA1, ST_SAN, ST_SANA
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] lvl_q, lvl_d;
  logic [1:0] good_q, good_d;
  logic [9:0] cg_q;
  logic       sync_q, sync_d;
  logic       even_q, even_d;

  logic [3:0] ones_all, ones_hi;
  logic       comma, invalid, data, cgbad, cg_even;

  assign ones_all = 4'($countones(rx_code_group_in));
  assign ones_hi  = 4'($countones(rx_code_group_in[9:4]));
  assign comma    = (rx_code_group_in[9:3] == 7'b0011111) ||
                    (rx_code_group_in[9:3] == 7'b1100000);
  assign invalid  = (ones_all < 4'd4) || (ones_all > 4'd6) ||
                    (ones_hi < 4'd2) || (ones_hi > 4'd4);
  assign data     = !invalid && !comma;
  // A comma seen while hunting defines the even position; otherwise parity just alternates.
  assign cg_even  = (state_q == ST_LOS && comma) ? 1'b1 : !even_q;
  assign cgbad    = invalid || (comma && !cg_even) || !signal_detect;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_LOS;
      lvl_q   <= 4'd0;
      good_q  <= 2'd0;
      cg_q    <= 10'd0;
      sync_q  <= 1'b0;
      even_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      good_q  <= good_d;
      cg_q    <= rx_code_group_in;
      sync_q  <= sync_d;
      even_q  <= even_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    good_d  = good_q;
    if (!signal_detect) begin
      state_d = ST_LOS;
      lvl_d   = 4'd0;
      good_d  = 2'd0;
    end else begin
      case (state_q)
        ST_LOS: begin
          if (comma) begin
            state_d = ST_CD;
            lvl_d   = 4'd1;
          end
        end
        ST_CD: begin
          if (data && lvl_q == ACQ_L) begin
            state_d = ST_SA1;
            lvl_d   = 4'd1;
          end else if (data) begin
            state_d = ST_AS;
          end else begin
            state_d = ST_LOS;
            lvl_d   = 4'd0;
          end
        end
        ST_AS: begin
          if (cgbad) begin
            state_d = ST_LOS;
            lvl_d   = 4'd0;
          end else if (comma) begin
            state_d = ST_CD;
            lvl_d   = lvl_q + 4'd1;
          end
        end
        ST_SA1: begin
          if (cgbad) begin
            state_d = ST_SAN;
            lvl_d   = 4'd2;
            good_d  = 2'd0;
          end
        end
        ST_SAN, ST_SANA: begin
          if (cgbad) begin
            good_d = 2'd0;
            if (lvl_q == LAST_L) begin
              state_d = ST_LOS;
              lvl_d   = 4'd0;
            end else begin
              state_d = ST_SAN;
              lvl_d   = lvl_q + 4'd1;
            end
          end else if (state_q == ST_SAN) begin
            state_d = ST_SANA;
            good_d  = 2'd1;
          end else if (good_q == GOOD_L) begin
            good_d = 2'd0;
            if (lvl_q == 4'd2) begin
              state_d = ST_SA1;
              lvl_d   = 4'd1;
            end else begin
              state_d = ST_SAN;
              lvl_d   = lvl_q - 4'd1;
            end
          end else if (good_q != 2'd3) begin
            good_d = good_q + 2'd1;
          end
        end
        default: begin
          state_d = ST_LOS;
          lvl_d   = 4'd0;
          good_d  = 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    sync_d = (state_d == ST_SA1) || (state_d == ST_SAN) || (state_d == ST_SANA);
    even_d = cg_even;
  end

  assign rx_code_group_out = cg_q;
  assign sync_status       = sync_q;
  assign rx_even           = even_q;

endmodule

// File: tb/tb_pcs_sync.sv
// tb/tb_pcs_sync.sv - directed table-driven bench for pcs_sync
module tb_pcs_sync;

  logic       clk;
  logic       RESET;
  logic [9:0] rx_code_group_in;
  logic       signal_detect;
  logic [9:0] rx_code_group_out;
  logic       sync_status;
  logic       rx_even;

  pcs_sync dut (
    .clk               (clk),
    .RESET             (RESET),
    .rx_code_group_in  (rx_code_group_in),
    .signal_detect     (signal_detect),
    .rx_code_group_out (rx_code_group_out),
    .sync_status       (sync_status),
    .rx_even           (rx_even)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] cg;
    logic       sd;
    logic       sync;
    logic       even;
  } vec_t;

  localparam logic [9:0] K  = 10'h0FA;
  localparam logic [9:0] D  = 10'h245;
  localparam logic [9:0] Z  = 10'h000;
  localparam logic [9:0] F  = 10'h3FF;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [9:0] cg, input logic sd, input logic s, input logic e);
    vec_t v;
    v.cg = cg; v.sd = sd; v.sync = s; v.even = e;
    tbl.push_back(v);
  endtask

  // six-cg acquisition from LOSS_OF_SYNC on a comma-first stream
  task automatic reacq();
    add(K, 1, 0, 1); add(D, 1, 0, 0);
    add(K, 1, 0, 1); add(D, 1, 0, 0);
    add(K, 1, 0, 1); add(D, 1, 1, 0);
  endtask

  initial begin
    RESET = 1'b1;
    rx_code_group_in = 10'h000;
    signal_detect = 1'b1;
    #1;
    chk("reset_out",  rx_code_group_out, 10'h000);
    chk("reset_sync", {9'd0, sync_status}, 10'd0);
    chk("reset_even", {9'd0, rx_even}, 10'd0);
    @(posedge clk); #1;
    RESET = 1'b0;

    // acquisition with /I2/ stream
    reacq();
    add(K, 1, 1, 1); add(D, 1, 1, 0);
    // four invalid cgs: loss on the fourth
    add(Z, 1, 1, 1); add(Z, 1, 1, 0); add(Z, 1, 1, 1); add(Z, 1, 0, 0);
    reacq();
    // three bad then 3x4 good: climb back to SA_1
    add(F, 1, 1, 1); add(F, 1, 1, 0); add(F, 1, 1, 1);
    for (int i = 0; i < 6; i++) begin
      add(D, 1, 1, 0); add(K, 1, 1, 1);
    end
    // from SA_1 it takes exactly four bad cgs to lose sync
    add(F, 1, 1, 0); add(F, 1, 1, 1); add(F, 1, 1, 0); add(F, 1, 0, 1);
    reacq();
    // stream slips by one cg: commas now odd
    add(D, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      add(K, 1, 1, 0); add(D, 1, 1, 1);
    end
    add(K, 1, 0, 0);
    add(D, 1, 0, 1);
    reacq();
    // signal_detect drop, then double comma during acquisition
    add(K, 0, 0, 1);
    add(K, 1, 0, 1); add(K, 1, 0, 0);
    add(D, 1, 0, 1); add(D, 1, 0, 0);
    reacq();

    for (int i = 0; i < tbl.size(); i++) begin
      rx_code_group_in = tbl[i].cg;
      signal_detect    = tbl[i].sd;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out", i),  rx_code_group_out, tbl[i].cg);
      chk($sformatf("vec%0d_sync", i), {9'd0, sync_status}, {9'd0, tbl[i].sync});
      chk($sformatf("vec%0d_even", i), {9'd0, rx_even}, {9'd0, tbl[i].even});
    end

    // asynchronous reset mid-stream while synced
    rx_code_group_in = K;
    signal_detect = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_sync", {9'd0, sync_status}, 10'd1);
    #2 RESET = 1'b1;
    #1;
    chk("async_rst_out",  rx_code_group_out, 10'h000);
    chk("async_rst_sync", {9'd0, sync_status}, 10'd0);
    chk("async_rst_even", {9'd0, rx_even}, 10'd0);
    rx_code_group_in = D;
    @(posedge clk); #1;
    chk("held_rst_out", rx_code_group_out, 10'h000);
    RESET = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rx_code_group_in = (i % 2 == 0) ? K : D;
      @(posedge clk); #1;
      chk($sformatf("resync%0d_sync", i), {9'd0, sync_status}, (i == 5) ? 10'd1 : 10'd0);
      chk($sformatf("resync%0d_out", i), rx_code_group_out, (i % 2 == 0) ? K : D);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
